// File: rtl/freeze_recovery_pkg.sv
// Shared types and constants for the freeze recovery block on the ECG sample path.
package freeze_recovery_pkg;

  localparam int DATA_W = 16;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_HOLD = 2'd1,
    ST_RAMP = 2'd2
  } state_e;

endpackage

// File: rtl/freeze_recovery_slew_step.sv
// One slew-limited step from cur toward target, using 17-bit difference arithmetic.
module slew_step
  import freeze_recovery_pkg::*;
#(
  parameter int MAX_STEP = 256
) (
  input  logic signed [DATA_W-1:0] cur_i,
  input  logic signed [DATA_W-1:0] target_i,
  output logic signed [DATA_W-1:0] next_o,
  output logic                     on_target_o
);

  localparam logic signed [DATA_W:0]   STEP17 = 17'(MAX_STEP);
  localparam logic        [DATA_W-1:0] STEP16 = 16'(MAX_STEP);

  logic signed [DATA_W:0] diff;

  // A clamped step never passes the target, so the 16-bit result cannot wrap.
  always_comb begin
    diff        = {target_i[DATA_W-1], target_i} - {cur_i[DATA_W-1], cur_i};
    on_target_o = (diff <= STEP17) && (diff >= -STEP17);
    if (on_target_o) begin
      next_o = target_i;
    end else if (diff > 0) begin
      next_o = cur_i + STEP16;
    end else begin
      next_o = cur_i - STEP16;
    end
  end

endmodule

// File: rtl/freeze_recovery.sv
// Substitutes the last good sample while freeze is high, then slew-limits back to the live signal.
module freeze_recovery
  import freeze_recovery_pkg::*;
#(
  parameter int MAX_STEP = 256,
  parameter int SETTLE   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_sample,
  input  logic                     freeze,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_sample,
  output logic [1:0]               state,
  output logic                     recovering,
  output logic [15:0]              event_count
);

  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

  state_e                   state_q, state_d;
  logic                     out_valid_q;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic signed [DATA_W-1:0] last_good_q, last_good_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic [7:0]               settle_q, settle_d;
  logic [15:0]              event_q, event_d;
  logic signed [DATA_W-1:0] step_next;
  logic                     step_on;

  slew_step #(.MAX_STEP(MAX_STEP)) u_step (
    .cur_i       (cur_q),
    .target_i    (in_sample),
    .next_o      (step_next),
    .on_target_o (step_on)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_PASS;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      last_good_q  <= '0;
      cur_q        <= '0;
      settle_q     <= '0;
      event_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= in_valid;
      out_sample_q <= out_sample_d;
      last_good_q  <= last_good_d;
      cur_q        <= cur_d;
      settle_q     <= settle_d;
      event_q      <= event_d;
    end
  end

  // Freeze is examined before in_valid in every state, so it wins on simultaneous events.
  always_comb begin
    state_d      = state_q;
    out_sample_d = out_sample_q;
    last_good_d  = last_good_q;
    cur_d        = cur_q;
    settle_d     = settle_q;
    event_d      = event_q;
    case (state_q)
      ST_PASS: begin
        if (freeze) begin
          state_d = ST_HOLD;
          if (event_q != CNT_MAX) event_d = event_q + 16'd1;
          if (in_valid) out_sample_d = last_good_q;
        end else if (in_valid) begin
          out_sample_d = in_sample;
          last_good_d  = in_sample;
        end
      end
      ST_HOLD: begin
        if (!freeze) begin
          state_d  = ST_RAMP;
          cur_d    = last_good_q;
          settle_d = '0;
        end else if (in_valid) begin
          out_sample_d = last_good_q;
        end
      end
      ST_RAMP: begin
        if (freeze) begin
          state_d     = ST_HOLD;
          last_good_d = cur_q;
          if (in_valid) out_sample_d = cur_q;
        end else if (in_valid) begin
          cur_d        = step_next;
          last_good_d  = step_next;
          out_sample_d = step_next;
          if (step_on) begin
            settle_d = settle_q + 8'd1;
            if (settle_q + 8'd1 == SETTLE_CNT) begin
              state_d      = ST_PASS;
              out_sample_d = in_sample;
            end
          end else begin
            settle_d = '0;
          end
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  assign out_valid   = out_valid_q;
  assign out_sample  = out_sample_q;
  assign state       = state_q;
  assign recovering  = (state_q == ST_RAMP);
  assign event_count = event_q;

endmodule
